// File: rtl/addsub_mp_seq_if.sv
// Requester-side bundle for the multi-precision add/subtract sequencer:
// start/ready handshake, operands in, registered result and flags out.
interface addsub_mp_seq_if #(
    parameter int WIDTH   = 8,
    parameter int NSLICES = 4
);
    localparam int W = WIDTH * NSLICES;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output start, op, a, b, cin,
        input  ready, busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op, a, b, cin,
        output ready, busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/addsub_mp_seq.sv
// Multi-precision add/subtract: one WIDTH-bit carry-chain slice is reused
// NSLICES times, least-significant slice first, with the carry held in a register.
module addsub_mp_seq #(
    parameter int WIDTH   = 8,
    parameter int NSLICES = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    addsub_mp_seq_if.slave bus
);
    localparam int W  = WIDTH * NSLICES;
    localparam int KW = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic            r_op;
    logic            r_carry;
    logic [KW-1:0]   r_k;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_result;
    logic            r_cout;
    logic            r_ovf;
    logic            r_zero;

    logic [WIDTH-1:0] w_a_slice;
    logic [WIDTH-1:0] w_b_slice;
    logic [WIDTH-1:0] w_sum;
    logic             w_c_out;
    logic             w_last;
    logic [W-1:0]     w_acc_next;

    // Subtract is a + ~b + ~cin, so only B and the initial carry get inverted.
    assign w_a_slice = r_a[r_k*WIDTH +: WIDTH];
    assign w_b_slice = r_b[r_k*WIDTH +: WIDTH] ^ {WIDTH{r_op}};
    assign {w_c_out, w_sum} = {1'b0, w_a_slice} + {1'b0, w_b_slice}
                            + {{WIDTH{1'b0}}, r_carry};
    assign w_last = (r_k == KW'(NSLICES - 1));

    generate
        for (genvar gi = 0; gi < NSLICES; gi++) begin : g_acc
            localparam logic [KW-1:0] SLICE_IDX = KW'(gi);
            assign w_acc_next[gi*WIDTH +: WIDTH] =
                (r_k == SLICE_IDX) ? w_sum : r_acc[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_op     <= 1'b0;
            r_carry  <= 1'b0;
            r_k      <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && r_ready) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_op    <= bus.op;
                        r_carry <= bus.cin ^ bus.op;
                        r_k     <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_c_out;
                    if (w_last) begin
                        // Flags come from the final slice, which holds the sign bit.
                        r_result <= w_acc_next;
                        r_cout   <= w_c_out ^ r_op;
                        r_ovf    <= (r_a[W-1] == w_b_slice[WIDTH-1])
                                 && (w_sum[WIDTH-1] != r_a[W-1]);
                        r_zero   <= (w_acc_next == '0);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;
    assign bus.zero   = r_zero;
endmodule

// File: tb/tb_addsub_mp_seq.sv
// Bench for addsub_mp_seq: directed vector table, handshake/reset corner
// sequences and random operands checked against an arithmetic reference model.
module tb_addsub_mp_seq;
    localparam int WIDTH   = 8;
    localparam int NSLICES = 4;
    localparam int W       = WIDTH * NSLICES;
    localparam int LAT     = NSLICES + 1;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    addsub_mp_seq_if #(.WIDTH(WIDTH), .NSLICES(NSLICES)) bus ();

    addsub_mp_seq #(.WIDTH(WIDTH), .NSLICES(NSLICES)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        logic         ez;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce modulo 2^W.
    function automatic res_t model(input logic op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        res_t   r;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = longint'($signed(a));
        longint sb   = longint'($signed(b));
        longint ci   = cin ? 64'sd1 : 64'sd0;
        longint smax = (longint'(1) << (W - 1)) - 1;
        longint smin = -(longint'(1) << (W - 1));
        longint full;
        longint sfull;
        if (!op) begin
            full   = ua + ub + ci;
            sfull  = sa + sb + ci;
            r.cout = (full >= (longint'(1) << W));
        end else begin
            full   = ua - ub - ci;
            sfull  = sa - sb - ci;
            r.cout = (full < 0);
        end
        r.result = full[W-1:0];
        r.ovf    = (sfull > smax) || (sfull < smin);
        r.zero   = (r.result == '0);
        return r;
    endfunction

    // Called at the negedge of cycle 1 after the accept edge.
    task automatic wait_done(output int lat, output bit ready_ok, output bit busy_ok);
        lat      = 0;
        ready_ok = 1'b1;
        busy_ok  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (bus.ready) ready_ok = 1'b0;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b1;
        for (int c = 0; c < 50 && !bus.ready; c++) @(negedge CLK);
        if (!bus.ready) ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin, input res_t exp);
        int lat;
        bit rdy_ok;
        bit busy_ok;
        bit ok;
        res_t got;
        @(negedge CLK);
        bus.op = op; bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        wait_ready(ok);
        check({tag, "_ready_wait"}, 64'(ok), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 1'($urandom); bus.cin = 1'($urandom);
        wait_done(lat, rdy_ok, busy_ok);
        got.result = bus.result; got.cout = bus.cout; got.ovf = bus.ovf; got.zero = bus.zero;
        $display("%s op=%s a=%h b=%h cin=%0d -> result=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
                 tag, op ? "sub" : "add", a, b, cin, got.result, got.cout, got.ovf, got.zero, lat);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_ready_low"}, 64'(rdy_ok), 64'd1);
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_result"}, 64'(got.result), 64'(exp.result));
        check({tag, "_flags"}, {61'd0, got.cout, got.ovf, got.zero},
              {61'd0, exp.cout, exp.ovf, exp.zero});
        @(negedge CLK);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_result_hold"}, 64'(bus.result), 64'(exp.result));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        bit   rdy_ok;
        bit   busy_ok;
        bit   ok;
        bit   done_seen;
        res_t e1;
        res_t e2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

        RESET = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_flags", {60'd0, bus.done, bus.cout, bus.ovf, bus.zero}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            e1 = '{vecs[i].er, vecs[i].ec, vecs[i].eo, vecs[i].ez};
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, e1);
        end

        // start held through a busy op with different operands on the bus
        e1 = model(1'b0, 32'hA000_0000, 32'h0C00_0000, 1'b0);
        e2 = model(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
        @(negedge CLK);
        bus.op = 1'b0; bus.a = 32'hA000_0000; bus.b = 32'h0C00_0000; bus.cin = 1'b0; bus.start = 1'b1;
        wait_ready(ok);
        check("hold_ready_wait", 64'(ok), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.a = 32'h1111_1111; bus.b = 32'h2222_2222;
        wait_done(lat, rdy_ok, busy_ok);
        $display("hold_first result=%h lat=%0d", bus.result, lat);
        check("hold_first_lat", 64'(lat), 64'(LAT));
        check("hold_first_result", 64'(bus.result), 64'(e1.result));
        @(negedge CLK);
        check("hold_between_ready", 64'(bus.ready), 64'd1);
        check("hold_between_result", 64'(bus.result), 64'(e1.result));
        @(negedge CLK);
        bus.start = 1'b0;
        check("hold_run_result", 64'(bus.result), 64'(e1.result));
        wait_done(lat, rdy_ok, busy_ok);
        $display("hold_second result=%h lat=%0d", bus.result, lat);
        check("hold_second_lat", 64'(lat), 64'(LAT));
        check("hold_second_result", 64'(bus.result), 64'(e2.result));

        // reset during slice k=2 of an in-flight op
        @(negedge CLK);
        bus.op = 1'b0; bus.a = 32'h0000_0001; bus.b = 32'h0000_0002; bus.cin = 1'b0; bus.start = 1'b1;
        wait_ready(ok);
        check("rstmid_ready_wait", 64'(ok), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        $display("rstmid ready=%0d busy=%0d result=%h", bus.ready, bus.busy, bus.result);
        check("rstmid_ready", 64'(bus.ready), 64'd1);
        check("rstmid_busy", 64'(bus.busy), 64'd0);
        check("rstmid_result", 64'(bus.result), 64'd0);
        check("rstmid_flags", {60'd0, bus.done, bus.cout, bus.ovf, bus.zero}, 64'd0);
        done_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done) done_seen = 1'b1;
            @(negedge CLK);
        end
        check("rstmid_no_done", 64'(done_seen), 64'd0);
        run_op("after_rst", 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0,
               model(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0));

        // reset and start on the same edge: reset wins
        @(negedge CLK);
        bus.op = 1'b0; bus.a = 32'h5; bus.b = 32'h6; bus.cin = 1'b0;
        bus.start = 1'b1; RESET = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0; RESET = 1'b0;
        $display("rst_start busy=%0d ready=%0d", bus.busy, bus.ready);
        check("rst_start_busy", 64'(bus.busy), 64'd0);
        check("rst_start_ready", 64'(bus.ready), 64'd1);

        for (int i = 0; i < 40; i++) begin
            logic op_r;
            logic cin_r;
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = '0;
                2:       ra = '1;
                default: ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            endcase
            case ($urandom_range(0, 3))
                0, 3:    rb = $urandom;
                1:       rb = '0;
                default: rb = '1;
            endcase
            op_r  = 1'($urandom);
            cin_r = 1'($urandom);
            run_op($sformatf("rnd%0d", i), op_r, ra, rb, cin_r, model(op_r, ra, rb, cin_r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/addsub_mp_seq.md
Name: addsub_mp_seq

Overview:
- Multi-precision add/subtract sequencer. Performs one N-slice-wide add or subtract by time-multiplexing a single WIDTH-bit carry-chain adder slice, with an operand-B inverter and carry-in inversion for subtract.
- Carry (or borrow) is held in a register and passed from slice to slice, least-significant slice first.
- Sits between a requester using a start/ready handshake and the shared narrow adder, so wide arithmetic costs one slice of carry-chain logic.

Parameters:
- WIDTH, 8, bits per adder slice.
- NSLICES, 4, number of slices per operation; total operand width is W = WIDTH*NSLICES.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  request; accepted on an edge where start=1 and ready=1.
- op  in  1  0 = add, 1 = subtract; sampled at accept.
- a  in  W  operand A; sampled at accept.
- b  in  W  operand B; sampled at accept.
- cin  in  1  carry-in for add, borrow-in for subtract; sampled at accept.
- ready  out  1  1 only in IDLE.
- busy  out  1  1 in RUN.
- done  out  1  one-cycle pulse when result, cout, ovf and zero are updated.
- result  out  W  last completed result; held until the next completion.
- cout  out  1  add: carry-out. Sub: borrow-out, the inverse of the final slice carry.
- ovf  out  1  signed two's-complement overflow of last op.
- zero  out  1  1 when last result == 0.

Behaviour:
- Clock and reset: one clock CLK; RESET is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0, zero=0. Internal carry register, slice index and operand registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start&&ready.
  - Latch a, b and op.
  - Carry register <= cin for add, ~cin for subtract.
  - Slice index k <= 0.
- RUN, per cycle k = 0..NSLICES-1:
  - Slice computes A[k] + B'[k] + c, where B' = b for add and ~b for subtract, and c = carry register.
  - Sum slice is written into the accumulator at bits [k*WIDTH +: WIDTH]; carry register <= slice carry-out.
  - After k = NSLICES-1 go to DONE; otherwise k <= k+1.
- Subtract therefore computes a - b - cin modulo 2^W.
- DONE, one cycle:
  - done=1; result <= accumulator.
  - cout <= final carry for add, ~final carry for subtract.
  - ovf <= (a[W-1] == B'[W-1]) && (sum[W-1] != a[W-1]).
  - zero <= (sum == 0).
  - Next state IDLE.
- Result/flag register timing: result and flags are registered on the edge leaving RUN, so they are valid in the DONE cycle and held afterwards.
- Latency: accept edge to done-high cycle is NSLICES+1 edges (5 at defaults). Minimum issue interval is NSLICES+2 cycles.
- start while not ready: ignored, with no effect on in-flight operands. The requester must hold start until it sees ready.
- Operand inputs may change freely after accept.
- RESET mid-operation (RUN or DONE): the next cycle is IDLE with reset values. The done pulse is suppressed and a partial result is never exposed.
- RESET and start together: RESET wins; the request is not accepted.
- Wrap-around: arithmetic is modulo 2^W. No saturation.

Test Plan:
- Add 0x000000FF + 0x00000001, cin=0 -> result=0x00000100, cout=0, ovf=0, zero=0. done high exactly 5 cycles after the accept edge. ready=0 for cycles 1..5.
- Subtract 0x00000000 - 0x00000001, cin=0 -> result=0xFFFFFFFF, cout(borrow)=1, ovf=0, zero=0. Subtract 0x00000005 - 0x00000003, cin=1 -> 0x00000001, cout=0.
- Add 0x7FFFFFFF + 0x00000001 -> result=0x80000000, ovf=1, cout=0. Subtract 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ovf=1, cout=0.
- Add 0xFFFFFFFF + 0x00000000, cin=1 -> result=0x00000000, cout=1, zero=1. Checks that the carry ripples across all slice boundaries.
- Hold start=1 with new operands (0x11111111 + 0x22222222) throughout a busy op -> in-flight result unaffected. The second op is accepted on the first ready cycle after done and yields 0x33333333. result holds its previous value between the two done pulses.
- Assert RESET for one cycle during RUN cycle k=2 -> next cycle state IDLE, ready=1, done never pulses, result/cout/ovf/zero = 0. A following op completes normally.
